// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list lowest-first,
// issuing one word access per set bit, then optionally writes the new base back.
module ldm_stm_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  up,
  input  logic                  pre,
  input  logic                  writeback,
  input  logic [3:0]            base_reg,
  input  logic [DATA_WIDTH-1:0] base_addr,
  input  logic [15:0]           reg_list,
  output logic                  busy,
  output logic                  done,
  output logic                  rf_wr_en,
  output logic [3:0]            rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [3:0]            rf_read_addr1,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] WORD = DATA_WIDTH'(4);

  state_t                state, state_nxt;
  logic                  ld_q, wb_q;
  logic [3:0]            base_reg_q;
  logic [15:0]           list_q, pend_q;
  logic [DATA_WIDTH-1:0] addr_q, final_q;

  logic [4:0]            cnt;
  logic [DATA_WIDTH-1:0] span, start_addr, final_base;
  logic [3:0]            cur;
  logic                  last, do_wb;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(reg_list[i]);
  end

  // span = 4*n bytes covered by the block
  assign span       = DATA_WIDTH'({cnt, 2'b00});
  assign start_addr = up ? (pre ? base_addr + WORD : base_addr)
                         : (pre ? base_addr - span : base_addr - span + WORD);
  assign final_base = up ? base_addr + span : base_addr - span;

  // Lowest set bit of the pending mask is the current register
  always_comb begin
    cur = '0;
    for (int i = 15; i >= 0; i--) if (pend_q[i]) cur = 4'(i);
  end

  assign last  = (pend_q & (pend_q - 16'd1)) == 16'd0;
  assign do_wb = wb_q && !(ld_q && list_q[base_reg_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ld_q       <= 1'b0;
      wb_q       <= 1'b0;
      base_reg_q <= '0;
      list_q     <= '0;
      pend_q     <= '0;
      addr_q     <= '0;
      final_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start && reg_list != 16'd0) begin
        ld_q       <= is_load;
        wb_q       <= writeback;
        base_reg_q <= base_reg;
        list_q     <= reg_list;
        pend_q     <= reg_list;
        addr_q     <= start_addr;
        final_q    <= final_base;
      end else if (state == XFER && mem_ready) begin
        pend_q <= pend_q & (pend_q - 16'd1);
        addr_q <= addr_q + WORD;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (reg_list != 16'd0) ? XFER : DONE;
      XFER: if (mem_ready && last) state_nxt = do_wb ? WB : DONE;
      WB:   state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    rf_wr_en      = 1'b0;
    rf_write_addr = '0;
    rf_write_data = '0;
    rf_read_addr1 = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state)
      XFER: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = ~ld_q;
        mem_addr = addr_q;
        if (!ld_q) begin
          rf_read_addr1 = cur;
          mem_wdata     = rf_read_data1;
        end else if (mem_ready) begin
          rf_wr_en      = 1'b1;
          rf_write_addr = cur;
          rf_write_data = mem_rdata;
        end
      end
      WB: begin
        busy          = 1'b1;
        rf_wr_en      = 1'b1;
        rf_write_addr = base_reg_q;
        rf_write_data = final_q;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: directed vector table, reset abort
// sequence and randomized runs against a list-walking reference model.
module tb_ldm_stm_seq;

  logic        clk, rst_n, start, is_load, up, pre, writeback;
  logic [3:0]  base_reg;
  logic [31:0] base_addr;
  logic [15:0] reg_list;
  logic        busy, done, rf_wr_en, mem_req, mem_we, mem_ready;
  logic [3:0]  rf_write_addr, rf_read_addr1;
  logic [31:0] rf_write_data, rf_read_data1, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] rf [16];
  assign rf_read_data1 = rf[rf_read_addr1];

  int checks = 0;
  int errors = 0;
  int cur_test = 0;

  ldm_stm_seq #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .up(up),
    .pre(pre), .writeback(writeback), .base_reg(base_reg),
    .base_addr(base_addr), .reg_list(reg_list), .busy(busy), .done(done),
    .rf_wr_en(rf_wr_en), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .rf_read_addr1(rf_read_addr1),
    .rf_read_data1(rf_read_data1), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld, up, pre, wb;
    logic [3:0]  br;
    logic [31:0] base;
    logic [15:0] lst;
    int          wmode;   // fixed wait states per access, -1 = random 0..3
    logic        poke;    // pulse start again while the run is in progress
    logic [31:0] first, fin;
    logic        ewb;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [test %0d] %s: got %h expected %h", cur_test, nm, act, exp);
    end
  endtask

  // Block occupies 4n bytes; the first access sits one word in when the
  // pre/post choice points into the block from the base end.
  function automatic void model(input logic ld, input logic up_i, input logic pre_i,
                                input logic wb_i, input logic [3:0] br,
                                input logic [31:0] base, input logic [15:0] lst,
                                output logic [31:0] first, output logic [31:0] fin,
                                output logic ewb);
    int n;
    logic [31:0] lowest;
    n      = $countones(lst);
    lowest = up_i ? base : base - 32'(4 * n);
    first  = lowest + ((pre_i == up_i) ? 32'd4 : 32'd0);
    fin    = up_i ? base + 32'(4 * n) : base - 32'(4 * n);
    ewb    = wb_i && (lst != 16'd0) && !(ld && lst[br]);
  endfunction

  // Advance to the next sampling point; the cycle after accept drops start,
  // scrambles the request inputs (they must already be latched) and optionally pokes start.
  task automatic next_cyc(input logic poke, inout bit fresh);
    @(negedge clk);
    start = fresh && poke;
    if (fresh) begin
      is_load   = 1'($urandom);
      up        = 1'($urandom);
      pre       = 1'($urandom);
      writeback = 1'($urandom);
      base_reg  = 4'($urandom);
      base_addr = $urandom;
      reg_list  = 16'($urandom);
    end
    fresh = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    int k, w;
    bit fresh;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) rf[i] = 32'(i + 9);
    rf[v.br] = v.base;
    @(negedge clk);
    start = 1'b1; is_load = v.ld; up = v.up; pre = v.pre; writeback = v.wb;
    base_reg = v.br; base_addr = v.base; reg_list = v.lst; mem_ready = 1'b0;
    @(posedge clk);
    fresh = 1'b1;
    k = 0;
    for (int r = 0; r < 16; r++) begin
      if (v.lst[r]) begin
        a = v.first + 32'(4 * k);
        w = (v.wmode >= 0) ? v.wmode : int'($urandom_range(0, 3));
        for (int c = 0; c <= w; c++) begin
          next_cyc(v.poke, fresh);
          mem_ready = (c == w);
          mem_rdata = $urandom;
          #1;
          chk("mem_req", mem_req, 1);
          chk("mem_we", mem_we, !v.ld);
          chk("mem_addr", mem_addr, a);
          chk("busy in xfer", busy, 1);
          chk("done in xfer", done, 0);
          if (!v.ld) begin
            chk("rf_read_addr1", rf_read_addr1, 32'(r));
            chk("mem_wdata", mem_wdata, rf[r]);
            chk("rf_wr_en store", rf_wr_en, 0);
          end else begin
            chk("mem_wdata load", mem_wdata, 0);
            chk("rf_wr_en load", rf_wr_en, mem_ready);
            if (mem_ready) begin
              chk("load wr addr", rf_write_addr, 32'(r));
              chk("load wr data", rf_write_data, mem_rdata);
            end
          end
          if (rf_wr_en) rf[rf_write_addr] = rf_write_data;
        end
        k++;
      end
    end
    if (v.ewb) begin
      next_cyc(v.poke, fresh);
      mem_ready = 1'($urandom);
      #1;
      chk("wb rf_wr_en", rf_wr_en, 1);
      chk("wb addr", rf_write_addr, v.br);
      chk("wb data", rf_write_data, v.fin);
      chk("wb busy", busy, 1);
      chk("wb mem_req", mem_req, 0);
      if (rf_wr_en) rf[rf_write_addr] = rf_write_data;
    end
    next_cyc(v.poke, fresh);
    mem_ready = 1'($urandom);
    #1;
    chk("done pulse", done, 1);
    chk("busy at done", busy, 0);
    chk("mem_req at done", mem_req, 0);
    chk("rf_wr_en at done", rf_wr_en, 0);
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b0;
    #1;
    chk("done cleared", done, 0);
    chk("idle busy", busy, 0);
    chk("idle mem_req", mem_req, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " rf_wr_en"}, rf_wr_en, 0);
    chk({nm, " mem_req"}, mem_req, 0);
    chk({nm, " mem_we"}, mem_we, 0);
    chk({nm, " mem_addr"}, mem_addr, 0);
    chk({nm, " mem_wdata"}, mem_wdata, 0);
    chk({nm, " rf_write_addr"}, rf_write_addr, 0);
    chk({nm, " rf_write_data"}, rf_write_data, 0);
    chk({nm, " rf_read_addr1"}, rf_read_addr1, 0);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0;
    writeback = 1'b0; base_reg = '0; base_addr = '0; reg_list = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) rf[i] = 32'(i + 9);

    //            ld  up  pre wb  br     base           lst       wm poke first          fin            ewb
    tbl[0] = '{1'b0,1'b1,1'b0,1'b1,4'd13,32'h0000_1000,16'h000E, 0,1'b0,32'h0000_1000,32'h0000_100C,1'b1};
    tbl[1] = '{1'b1,1'b0,1'b1,1'b1,4'd13,32'h0000_2000,16'h8001, 0,1'b0,32'h0000_1FF8,32'h0000_1FF8,1'b1};
    tbl[2] = '{1'b1,1'b1,1'b0,1'b1,4'd4, 32'h0000_3000,16'h0010, 0,1'b0,32'h0000_3000,32'h0000_3004,1'b0};
    tbl[3] = '{1'b0,1'b1,1'b1,1'b0,4'd0, 32'h0000_0000,16'h0003, 2,1'b0,32'h0000_0004,32'h0000_0008,1'b0};
    tbl[4] = '{1'b0,1'b1,1'b0,1'b1,4'd3, 32'h0000_0077,16'h0000, 0,1'b1,32'h0000_0000,32'h0000_0000,1'b0};
    tbl[5] = '{1'b0,1'b0,1'b0,1'b1,4'd2, 32'h0000_0100,16'h0024, 1,1'b1,32'h0000_00FC,32'h0000_00F8,1'b1};
    tbl[6] = '{1'b1,1'b1,1'b1,1'b1,4'd7, 32'hFFFF_FFF8,16'h0003,-1,1'b0,32'hFFFF_FFFC,32'h0000_0000,1'b1};
    tbl[7] = '{1'b0,1'b0,1'b1,1'b1,4'd0, 32'h0000_0040,16'hFFFF, 0,1'b0,32'h0000_0000,32'h0000_0000,1'b1};
    tbl[8] = '{1'b1,1'b0,1'b0,1'b1,4'd5, 32'h0000_0200,16'h0060, 0,1'b1,32'h0000_01FC,32'h0000_01F8,1'b0};

    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int t = 0; t < 9; t++) begin
      cur_test = t;
      run_op(tbl[t]);
    end

    // Reset during the second transfer of a 4-register load
    cur_test = 100;
    for (int i = 0; i < 16; i++) rf[i] = 32'(i + 9);
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; up = 1'b1; pre = 1'b0; writeback = 1'b1;
    base_reg = 4'd13; base_addr = 32'h500; reg_list = 16'h00F0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h11;
    #1;
    chk("abort first wr", rf_wr_en, 1);
    chk("abort first addr", rf_write_addr, 4);
    if (rf_wr_en) rf[rf_write_addr] = rf_write_data;
    @(negedge clk);
    mem_rdata = 32'h22;
    #1;
    chk("abort second addr", mem_addr, 32'h504);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      #1;
      chk("post-abort rf_wr_en", rf_wr_en, 0);
      chk("post-abort done", done, 0);
      chk("post-abort mem_req", mem_req, 0);
      if (rf_wr_en) rf[rf_write_addr] = rf_write_data;
    end
    chk("R4 loaded", rf[4], 32'h11);
    chk("R5 untouched", rf[5], 32'd14);
    mem_ready = 1'b0;
    cur_test = 101;
    run_op(tbl[1]);

    for (int t = 0; t < 24; t++) begin
      cur_test = 200 + t;
      v.ld = 1'($urandom); v.up = 1'($urandom); v.pre = 1'($urandom);
      v.wb = 1'($urandom); v.br = 4'($urandom);
      v.base = $urandom & 32'hFFFF_FFFC;
      v.lst = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      v.wmode = -1;
      v.poke = 1'($urandom);
      model(v.ld, v.up, v.pre, v.wb, v.br, v.base, v.lst, v.first, v.fin, v.ewb);
      run_op(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
